serial_frame_rx: RTL and testbench

Receive stage downstream of the parallel/serial shift register. It consumes the register's serial output one bit per enable strobe and detects a start bit. It collects a WIDTH-bit data word MSB-first, matching shift-left order, then checks even parity and the stop bit. Each good word is presented on a one-entry valid/ready output buffer with parity, framing and overrun status.

---
 rtl/serial_frame_pkg.sv | 20 ++
 rtl/serial_frame_rx_if.sv | 24 ++
 rtl/frame_out_buf.sv | 57 +++++
 rtl/serial_frame_rx.sv | 110 +++++++++++
 tb/tb_serial_frame_rx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Bit-counter width; never below one bit so the counter stays a legal vector.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial input, bit strobe and the received-word valid/ready bundle.
interface serial_frame_rx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             bit_en;
    logic             s_in;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_perr;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    modport master (
        input  bit_en, s_in, out_ready,
        output out_data, out_valid, out_perr, frame_err, overrun, busy
    );

    modport slave (
        output bit_en, s_in, out_ready,
        input  out_data, out_valid, out_perr, frame_err, overrun, busy
    );
endinterface

// File: rtl/frame_out_buf.sv
// One-entry valid/ready holding register; drops a new word when full and not draining.
module frame_out_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             perr_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             perr_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             overrun_q, overrun_d;
    logic             load;

    always_comb begin
        load      = commit_i & (~valid_q | ready_i);
        data_d    = data_q;
        perr_d    = perr_q;
        valid_d   = valid_q;
        overrun_d = commit_i & valid_q & ~ready_i;
        if (load) begin
            data_d  = data_i;
            perr_d  = perr_i;
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            perr_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            perr_q    <= perr_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign perr_o    = perr_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Strobed serial frame receiver: start, MSB-first data, optional even parity, stop.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PARITY_EN = 1
) (
    input logic               clk,
    input logic               rst_n,
    serial_frame_rx_if.master bus
);

    localparam int unsigned CntW   = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam bit          ParEn  = (PARITY_EN != 0);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic             ferr_q, ferr_d;
    logic             commit;
    logic             perr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        ferr_d  = 1'b0;
        commit  = 1'b0;
        if (bus.bit_en) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.s_in == START_LEVEL) begin
                        state_d = StData;
                        cnt_d   = '0;
                        shift_d = '0;
                        par_d   = 1'b0;
                    end
                end
                StData: begin
                    shift_d = {shift_q[WIDTH-2:0], bus.s_in};
                    par_d   = par_q ^ bus.s_in;
                    if (cnt_q == CntLast) begin
                        state_d = ParEn ? StParity : StStop;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    par_d   = par_q ^ bus.s_in;
                    state_d = StStop;
                end
                StStop: begin
                    if (bus.s_in == IDLE_LEVEL) begin
                        commit  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitIdle;
                    end
                end
                StWaitIdle: begin
                    // Line held low (break) must return to idle before a new start counts.
                    if (bus.s_in == IDLE_LEVEL) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
        end
    end

    // Odd ones count over data plus parity bit means a parity error.
    assign perr = ParEn ? par_q : 1'b0;

    frame_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .commit_i (commit),
        .data_i   (shift_q),
        .perr_i   (perr),
        .ready_i  (bus.out_ready),
        .data_o   (bus.out_data),
        .valid_o  (bus.out_valid),
        .perr_o   (bus.out_perr),
        .overrun_o(bus.overrun)
    );

    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (WIDTH=8, PARITY_EN=1) with a word scoreboard.
module tb_serial_frame_rx;

    logic clk;
    logic rst_n;

    serial_frame_rx_if #(.WIDTH(8)) bus ();

    serial_frame_rx #(
        .WIDTH    (8),
        .PARITY_EN(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       p;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        bit         flip;
        int         gap;
    } vec_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   ferr_cnt;
    int   ovr_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
    task automatic drive(input logic en, input logic s);
        bus.bit_en = en;
        bus.s_in   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        for (int i = 0; i < gap; i++) drive(1'b0, 1'($urandom));
        drive(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip, input logic stop,
                              input int gap, input bit rdy_on_stop);
        send_bit(1'b0, gap);
        for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
        send_bit((^d) ^ flip, gap);
        if (rdy_on_stop) bus.out_ready = 1'b1;
        send_bit(stop, gap);
        if (rdy_on_stop) bus.out_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) drive(1'b0, 1'b1);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.frame_err) ferr_cnt++;
                if (bus.overrun) ovr_cnt++;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got word %0h expected none", bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_data", 32'(bus.out_data), 32'(e.d));
                        chk("sb_perr", 32'(bus.out_perr), 32'(e.p));
                    end
                end
            end
        end
    end

    initial begin
        vec_t vecs[6];
        int   f0;
        int   o0;
        exp_t e;

        vecs[0] = '{data: 8'hA5, flip: 1'b0, gap: 0};
        vecs[1] = '{data: 8'hA5, flip: 1'b1, gap: 0};
        vecs[2] = '{data: 8'h00, flip: 1'b0, gap: 1};
        vecs[3] = '{data: 8'hFF, flip: 1'b1, gap: 0};
        vecs[4] = '{data: 8'h80, flip: 1'b0, gap: 2};
        vecs[5] = '{data: 8'h01, flip: 1'b1, gap: 0};

        checks = 0; errors = 0; ferr_cnt = 0; ovr_cnt = 0;
        rst_n = 1'b0;
        bus.bit_en = 1'b0;
        bus.s_in = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b1);

        // Reset mid-frame with a word already buffered.
        send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data", 32'(bus.out_data), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_flags", {30'd0, bus.frame_err, bus.overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        f0 = ferr_cnt;
        for (int i = 0; i < 20; i++) send_bit(1'b1, 0);
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_perr", 32'(bus.out_perr), 32'd0);
        chk("idle_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Good frame, held until consumer ready.
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
        chk("good_valid", 32'(bus.out_valid), 32'd1);
        chk("good_data", 32'(bus.out_data), 32'hA5);
        chk("good_perr", 32'(bus.out_perr), 32'd0);
        e = '{d: 8'hA5, p: 1'b0};
        exp_q.push_back(e);
        bus.out_ready = 1'b1;
        drain("good_drain");

        // Parity error still delivered.
        bus.out_ready = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
        chk("par_data", 32'(bus.out_data), 32'hA5);
        chk("par_perr", 32'(bus.out_perr), 32'd1);
        chk("par_ferr", 32'(bus.frame_err), 32'd0);
        e = '{d: 8'hA5, p: 1'b1};
        exp_q.push_back(e);
        bus.out_ready = 1'b1;
        drain("par_drain");

        // Table-driven frames with the consumer always ready.
        for (int v = 0; v < 6; v++) begin
            e = '{d: vecs[v].data, p: vecs[v].flip};
            exp_q.push_back(e);
            send_frame(vecs[v].data, vecs[v].flip, 1'b1, vecs[v].gap, 1'b0);
            chk("vec_valid", 32'(bus.out_valid), 32'd1);
            chk("vec_ferr", 32'(bus.frame_err), 32'd0);
            drain("vec_drain");
        end

        // Framing error, break, recovery.
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
        chk("ferr_pulse", 32'(bus.frame_err), 32'd1);
        chk("ferr_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
        chk("ferr_single", 32'(ferr_cnt - f0), 32'd1);
        chk("break_busy", 32'(bus.busy), 32'd1);
        send_bit(1'b1, 0);
        e = '{d: 8'h81, p: 1'b0};
        exp_q.push_back(e);
        send_frame(8'h81, 1'b0, 1'b1, 0, 1'b0);
        drain("ferr_drain");
        chk("ferr_total", 32'(ferr_cnt - f0), 32'd1);

        // Overrun with consumer stalled.
        bus.out_ready = 1'b0;
        o0 = ovr_cnt;
        e = '{d: 8'h11, p: 1'b0};
        exp_q.push_back(e);
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0);
        chk("ovr_pulse", 32'(bus.overrun), 32'd1);
        drive(1'b0, 1'b1);
        chk("ovr_count", 32'(ovr_cnt - o0), 32'd1);
        chk("ovr_kept", 32'(bus.out_data), 32'h11);
        bus.out_ready = 1'b1;
        drain("ovr_drain");

        // Accept coinciding with commit: no overrun.
        bus.out_ready = 1'b0;
        o0 = ovr_cnt;
        e = '{d: 8'h11, p: 1'b0};
        exp_q.push_back(e);
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b1);
        drive(1'b0, 1'b1);
        chk("acc_no_ovr", 32'(ovr_cnt - o0), 32'd0);
        chk("acc_valid", 32'(bus.out_valid), 32'd1);
        chk("acc_data", 32'(bus.out_data), 32'h22);
        e = '{d: 8'h22, p: 1'b0};
        exp_q.push_back(e);
        bus.out_ready = 1'b1;
        drain("acc_drain");

        // Sparse strobes, back-to-back frames.
        e = '{d: 8'hF0, p: 1'b0};
        exp_q.push_back(e);
        e = '{d: 8'h0F, p: 1'b0};
        exp_q.push_back(e);
        send_frame(8'hF0, 1'b0, 1'b1, 3, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b1, 3, 1'b0);
        drain("sparse_drain");

        drive(1'b0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
